iter_div: RTL

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 111 +++++++++++
 1 files changed

// File: rtl/iter_div.sv
// rtl/iter_div.sv - iterative restoring 32-bit divider, signed or unsigned, one quotient bit per cycle
module iter_div #(
   parameter int SIGNED = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        s_axis_divisor_tvalid,
   output logic        s_axis_divisor_tready,
   input  logic [31:0] s_axis_divisor_tdata,
   input  logic        s_axis_dividend_tvalid,
   output logic        s_axis_dividend_tready,
   input  logic [31:0] s_axis_dividend_tdata,
   output logic        m_axis_dout_tvalid,
   output logic [63:0] m_axis_dout_tdata
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  cnt;
   logic [63:0] pr;         // {partial remainder, dividend bits shifting into quotient}
   logic [31:0] dmag;
   logic        q_neg;
   logic        r_neg;
   logic        div_zero;

   logic        accept;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] trial;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   // Both channels transfer together or not at all.
   assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

   // Gated by resetn so ready drops the moment reset asserts, even with tvalid high.
   assign s_axis_divisor_tready  = resetn && accept;
   assign s_axis_dividend_tready = resetn && accept;

   assign a_neg = (SIGNED != 0) && s_axis_dividend_tdata[31];
   assign b_neg = (SIGNED != 0) && s_axis_divisor_tdata[31];
   assign a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
   assign b_mag = b_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

   // Shifted remainder (33 bits) minus divisor; bit 32 set means borrow, so the step restores.
   assign trial = pr[63:31] - {1'b0, dmag};

   assign q_fix = q_neg ? -pr[31:0]  : pr[31:0];
   assign r_fix = r_neg ? -pr[63:32] : pr[63:32];

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: 32 CALC cycles, then one DONE cycle that publishes the result.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (cnt == 6'd31) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, shift-subtract iteration, sign fix-up and result register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt                <= 6'd0;
         pr                 <= 64'd0;
         dmag               <= 32'd0;
         q_neg              <= 1'b0;
         r_neg              <= 1'b0;
         div_zero           <= 1'b0;
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tdata  <= 64'd0;
      end else begin
         m_axis_dout_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  pr       <= {32'd0, a_mag};
                  dmag     <= b_mag;
                  q_neg    <= a_neg ^ b_neg;
                  r_neg    <= a_neg;
                  div_zero <= (s_axis_divisor_tdata == 32'd0);
                  cnt      <= 6'd0;
               end
            end
            CALC: begin
               if (!trial[32]) pr <= {trial[31:0], pr[30:0], 1'b1};
               else            pr <= {pr[62:0], 1'b0};
               cnt <= cnt + 6'd1;
            end
            DONE: begin
               // Divide by zero: quotient all ones regardless of sign, remainder is the dividend.
               m_axis_dout_tvalid <= 1'b1;
               m_axis_dout_tdata  <= div_zero ? {r_fix, 32'hFFFF_FFFF} : {r_fix, q_fix};
            end
            default: ;
         endcase
      end
   end

endmodule
